unary_add_driver_1_10: RTL and testbench

Binary-side driver for the 10-bit unary adder: accepts two binary operands over a valid/ready handshake and serialises them into the adder's unary A/B input streams. It then drives the adder's drain (write) phase, counts the unary `dout` pulses coming back, merges in the adder's overflow flag `C`, and presents the binary sum on a result handshake. It sits between a binary producer/consumer and the unary adder, owning `en` and `read_or_write`.

---
 rtl/unary_add_driver_1_10.sv | 181 ++++++++++++++++++
 tb/tb_unary_add_driver_1_10.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/unary_add_driver_1_10.sv
// unary_add_driver_1_10
//
// Binary-side driver for a W-bit unary adder. Accepts an operand pair over a
// valid/ready handshake and serialises both operands into left-aligned unary
// streams on A/B (accumulate phase). It then inserts one gap cycle and drains
// the adder (write phase), counting the returned dout pulses. The result is
// presented as {carry, count} on a result handshake.
//
// Optional feature (macro UNARY_DRV_CHECK_EN): keeps a binary reference sum
// and raises a sticky chk_err when the drained result disagrees with it.
// When the macro is undefined, chk_err is tied to 0.
//
// Ports:
//   clk, rst        - clock (rising edge), synchronous active-high reset
//   op_valid/ready  - operand handshake; op_ready is high only in IDLE
//   op_a, op_b      - W-bit binary operands
//   A, B            - unary operand streams to the adder
//   en              - adder enable
//   read_or_write   - 0 = accumulate phase, 1 = drain phase
//   dout            - adder drain stream (one cycle of pipeline latency)
//   C               - adder registered overflow flag
//   res_valid/ready - result handshake; res_sum held until taken
//   res_sum         - W+1-bit binary sum {carry, drained count}
//   chk_err         - sticky self-check mismatch flag
module unary_add_driver_1_10 #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         A,
    output logic         B,
    output logic         en,
    output logic         read_or_write,
    input  logic         dout,
    input  logic         C,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W:0]   res_sum,
    output logic         chk_err
);

    typedef enum logic [2:0] {StIdle, StRead, StGap, StWrite, StDone} state_e;

    state_e       state;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] len_q;
    logic [W-1:0] k_q;
    logic [W-1:0] cnt_q;
    logic         carry_q;
    logic         first_q;

    logic [W-1:0] k_next;
    logic [W-1:0] len_new;
    logic [W:0]   drained_sum;
    logic         done_load;

    assign k_next      = k_q + W'(1);
    assign len_new     = (op_a >= op_b) ? op_a : op_b;
    assign drained_sum = {carry_q, cnt_q};
    // Drain ends on the first low dout after the ignored latency cycle.
    assign done_load   = (state == StWrite) && !first_q && !dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= StIdle;
            op_ready      <= 1'b0;
            A             <= 1'b0;
            B             <= 1'b0;
            en            <= 1'b0;
            read_or_write <= 1'b0;
            res_valid     <= 1'b0;
            res_sum       <= '0;
            a_q           <= '0;
            b_q           <= '0;
            len_q         <= '0;
            k_q           <= '0;
            cnt_q         <= '0;
            carry_q       <= 1'b0;
            first_q       <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    // op_ready comes up one cycle after reset releases.
                    if (!op_ready) begin
                        op_ready <= 1'b1;
                    end else if (op_valid) begin
                        op_ready      <= 1'b0;
                        a_q           <= op_a;
                        b_q           <= op_b;
                        len_q         <= len_new;
                        k_q           <= '0;
                        cnt_q         <= '0;
                        carry_q       <= 1'b0;
                        en            <= 1'b1;
                        read_or_write <= 1'b0;
                        if (len_new != '0) begin
                            state <= StRead;
                            A     <= (op_a != '0);
                            B     <= (op_b != '0);
                        end else begin
                            state <= StGap;
                            A     <= 1'b0;
                            B     <= 1'b0;
                        end
                    end
                end
                StRead: begin
                    carry_q <= carry_q | C;
                    k_q     <= k_next;
                    if (k_next == len_q) begin
                        state <= StGap;
                        A     <= 1'b0;
                        B     <= 1'b0;
                    end else begin
                        A <= (k_next < a_q);
                        B <= (k_next < b_q);
                    end
                end
                StGap: begin
                    // Gap lets the adder's registered C catch the last increment.
                    carry_q       <= carry_q | C;
                    state         <= StWrite;
                    read_or_write <= 1'b1;
                    first_q       <= 1'b1;
                end
                StWrite: begin
                    if (first_q) begin
                        first_q <= 1'b0;
                        carry_q <= carry_q | C;
                    end else if (dout) begin
                        cnt_q <= cnt_q + W'(1);
                    end else begin
                        en            <= 1'b0;
                        read_or_write <= 1'b0;
                        res_sum       <= drained_sum;
                        res_valid     <= 1'b1;
                        state         <= StDone;
                    end
                end
                StDone: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_ready  <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

`ifdef UNARY_DRV_CHECK_EN
    logic [W:0] ref_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q   <= '0;
            chk_err <= 1'b0;
        end else begin
            if (state == StIdle && op_ready && op_valid) begin
                ref_q <= {1'b0, op_a} + {1'b0, op_b};
            end
            if (done_load && (drained_sum != ref_q)) begin
                chk_err <= 1'b1;
            end
        end
    end
`else
    logic unused_done_load;
    assign unused_done_load = done_load;
    assign chk_err          = 1'b0;
`endif

endmodule

// File: tb/tb_unary_add_driver_1_10.sv
// Bench for unary_add_driver_1_10: a behavioural unary adder closes the loop,
// and a timing-rule model predicts every output on every cycle.
module tb_unary_add_driver_1_10;
    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         op_valid;
    logic         op_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         A;
    logic         B;
    logic         en;
    logic         read_or_write;
    logic         dout;
    logic         C;
    logic         res_valid;
    logic         res_ready;
    logic [W:0]   res_sum;
    logic         chk_err;

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 1'b0;

    always #5 clk = ~clk;

    unary_add_driver_1_10 #(.W(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_a          (op_a),
        .op_b          (op_b),
        .A             (A),
        .B             (B),
        .en            (en),
        .read_or_write (read_or_write),
        .dout          (dout),
        .C             (C),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_sum       (res_sum),
        .chk_err       (chk_err)
    );

    // Unary adder: counts A and B pulses, flags wrap, drains one pulse per cycle.
    logic [W-1:0] add_cnt;
    logic [W:0]   add_inc;
    assign add_inc = {1'b0, add_cnt} + (W+1)'(A) + (W+1)'(B);

    always @(posedge clk) begin
        if (rst) begin
            add_cnt <= '0;
            C       <= 1'b0;
            dout    <= 1'b0;
        end else if (en && !read_or_write) begin
            add_cnt <= add_inc[W-1:0];
            if (add_inc[W]) C <= 1'b1;
            dout <= 1'b0;
        end else if (en && read_or_write) begin
            C <= 1'b0;
            if (add_cnt != '0) begin
                dout    <= 1'b1;
                add_cnt <= add_cnt - W'(1);
            end else begin
                dout <= 1'b0;
            end
        end else begin
            dout <= 1'b0;
        end
    end

    // Reference: mode 0 idle, 1 busy (m_t = cycles since accept), 2 done.
    int m_mode, m_t, m_a, m_b, m_len, m_slow, m_sum;
    bit m_rdy;

    always @(posedge clk) begin
        if (rst) begin
            m_mode <= 0;
            m_rdy  <= 1'b0;
            m_t    <= 0;
        end else begin
            case (m_mode)
                0: begin
                    if (m_rdy && op_valid) begin
                        m_mode <= 1;
                        m_t    <= 1;
                        m_rdy  <= 1'b0;
                        m_a    <= int'(op_a);
                        m_b    <= int'(op_b);
                        m_len  <= (op_a > op_b) ? int'(op_a) : int'(op_b);
                        m_sum  <= int'(op_a) + int'(op_b);
                        m_slow <= (int'(op_a) + int'(op_b)) % (1 << W);
                    end else begin
                        m_rdy <= 1'b1;
                    end
                end
                1: begin
                    if (m_t == m_len + m_slow + 3) m_mode <= 2;
                    else m_t <= m_t + 1;
                end
                default: begin
                    if (res_ready) begin
                        m_mode <= 0;
                        m_rdy  <= 1'b1;
                    end
                end
            endcase
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cmp_cycle();
        logic e_a, e_b, e_en, e_rw, e_v;
        logic [W:0]  e_sum;
        logic [W:0]  g_sum;
        logic [17:0] got_v;
        logic [17:0] exp_v;
        e_a = 0; e_b = 0; e_en = 0; e_rw = 0; e_v = 0; e_sum = '0;
        if (m_mode == 1) begin
            e_en = 1;
            if (m_t <= m_len) begin
                e_a = (m_t - 1 < m_a);
                e_b = (m_t - 1 < m_b);
            end else if (m_t > m_len + 1) begin
                e_rw = 1;
            end
        end else if (m_mode == 2) begin
            e_v   = 1;
            e_sum = (W+1)'(m_sum);
        end
        g_sum = e_v ? res_sum : '0;
        got_v = {op_ready, A, B, en, read_or_write, res_valid, chk_err, g_sum};
        exp_v = {m_rdy, e_a, e_b, e_en, e_rw, e_v, 1'b0, e_sum};
        check("cycle_outputs", int'(got_v), int'(exp_v));
    endtask

    always @(negedge clk) if (cmp_on) cmp_cycle();

    task automatic run_op(input int a, input int b, input int exp_sum, input int exp_lat,
                          input int hold);
        int n, na, nb;
        bit ok;
        @(negedge clk);
        op_a = W'(a); op_b = W'(b); op_valid = 1'b1; res_ready = 1'b0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_rdy) begin ok = 1; break; end
            @(negedge clk);
        end
        check("accept", int'(ok), 1);
        @(posedge clk);
        #1 op_valid = 1'b0;
        n = 0; na = 0; nb = 0; ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            n++;
            if (res_valid) begin ok = 1; break; end
            na += int'(A);
            nb += int'(B);
        end
        check("res_valid_seen", int'(ok), 1);
        check("latency", n, exp_lat);
        check("a_pulses", na, a);
        check("b_pulses", nb, b);
        check("res_sum", int'(res_sum), exp_sum);
        for (int i = 0; i < hold; i++) begin
            op_valid = (i % 3 == 0);
            op_a = W'(99); op_b = W'(99);
            check("hold_sum", int'(res_sum), exp_sum);
            check("hold_op_ready", int'(op_ready), 0);
            @(negedge clk);
        end
        op_valid  = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic reset_mid_read();
        bit ok;
        @(negedge clk);
        op_a = W'(500); op_b = W'(200); op_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_rdy) begin ok = 1; break; end
            @(negedge clk);
        end
        check("accept_rst_op", int'(ok), 1);
        @(posedge clk);
        #1 op_valid = 1'b0;
        repeat (100) @(negedge clk);
        check("mid_read_en", int'(en), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_outputs",
              int'({op_ready, A, B, en, read_or_write, res_valid, chk_err, res_sum}), 0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              int'({op_ready, A, B, en, read_or_write, res_valid, chk_err, res_sum}), 0);
        cmp_on = 1'b1;
        rst    = 1'b0;
        run_op(3, 5, 8, 17, 0);
        run_op(0, 0, 0, 4, 0);
        run_op(1023, 1, 1024, 1027, 0);
        run_op(1023, 1023, 2046, 2049, 10);
        run_op(6, 7, 13, 24, 0);
        reset_mid_read();
        run_op(2, 2, 4, 10, 0);
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
